// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the serial DAC controllers.
// Frame geometry matches the board's 12-bit DAC 16-bit write word.
package dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int PAD_W   = FRAME_W - DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

endpackage

// File: rtl/dac_sclk_tick.sv
// Half-period tick generator for the gated DAC serial clock.
// Counts only while enabled; a clear restarts the half-period.
module dac_sclk_tick #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DW = $clog2(HALF_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(HALF_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_serial_ctrl.sv
// One 16-bit serial write per accepted sample, MSB first,
// with a gated SCLK and an enforced SYNC-high gap.
module dac_serial_ctrl #(
  parameter int HALF_DIV  = 4,
  parameter int GAP_TICKS = 2,
  parameter int DATA_W    = dac_pkg::DATA_W,
  parameter int FRAME_W   = dac_pkg::FRAME_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] SAMPLE_DATA,
  input  logic              SAMPLE_VALID,
  output logic              SAMPLE_READY,
  output logic              DAC_SCLK,
  output logic              DAC_SYNC,
  output logic              DAC_DIN,
  output logic              BUSY,
  output logic              DONE
);

  import dac_pkg::*;

  localparam int PAD = FRAME_W - DATA_W;
  localparam int BW  = $clog2(FRAME_W);
  localparam int GW  = $clog2(GAP_TICKS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  state_e state_q, state_d;

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_in;
  logic [BW-1:0]      bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic sclk_q, sclk_d;
  logic sync_q, sync_d;
  logic din_q, din_d;
  logic done_q, done_d;
  logic tick;
  logic accept;

  assign frame_in = {{PAD{1'b0}}, SAMPLE_DATA};
  assign accept   = SAMPLE_VALID & (state_q == IDLE);

  dac_sclk_tick #(
    .HALF_DIV(HALF_DIV)
  ) u_tick (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .en_i  (state_q != IDLE),
    .clr_i (accept),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    din_d   = din_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = frame_in;
          din_d   = frame_in[FRAME_W-1];
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          // data only moves on the rising half so DIN straddles each fall
          if (!sclk_q) begin
            if (bit_q == BIT_LAST) begin
              sync_d  = 1'b1;
              din_d   = 1'b0;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              shift_d = shift_q << 1;
              din_d   = shift_q[FRAME_W-2];
              bit_d   = bit_q + BW'(1);
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      din_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  assign SAMPLE_READY = (state_q == IDLE);
  assign BUSY         = (state_q != IDLE);
  assign DAC_SCLK     = sclk_q;
  assign DAC_SYNC     = sync_q;
  assign DAC_DIN      = din_q;
  assign DONE         = done_q;

endmodule
